// File: rtl/control_minado_pkg.sv
// Shared definitions for the mining sweep controller: default widths,
// FSM state encoding and the saturating attempt-counter helper.
package control_minado_pkg;

    localparam int NONCE_W_DEF = 32;
    localparam int HASH_W_DEF  = 32;
    localparam int ATTEMPTS_W  = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_FINISH = 3'd5
    } state_e;

    // Increment that sticks at all-ones instead of wrapping back to zero.
    function automatic logic [ATTEMPTS_W-1:0] sat_inc(input logic [ATTEMPTS_W-1:0] v);
        if (v == {ATTEMPTS_W{1'b1}}) begin
            return v;
        end
        return v + ATTEMPTS_W'(1);
    endfunction

endpackage

// File: rtl/generador_nonce.sv
// Nonce register for the sweep: loads base and limit together, steps the
// nonce by one on request and flags when the current nonce is the limit.
module generador_nonce
    import control_minado_pkg::*;
#(
    parameter int NONCE_W = NONCE_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               inc,
    input  logic [NONCE_W-1:0] base,
    input  logic [NONCE_W-1:0] limit,
    output logic [NONCE_W-1:0] nonce,
    output logic               last
);

    logic [NONCE_W-1:0] nonce_q;
    logic [NONCE_W-1:0] nonce_d;
    logic [NONCE_W-1:0] limit_q;
    logic [NONCE_W-1:0] limit_d;

    // Load wins over increment; an increment at the limit is refused so the nonce never wraps.
    always_comb begin
        nonce_d = nonce_q;
        limit_d = limit_q;
        if (load) begin
            nonce_d = base;
            limit_d = limit;
        end else if (inc && (nonce_q != limit_q)) begin
            nonce_d = nonce_q + NONCE_W'(1);
        end
    end

    // Nonce and limit registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            nonce_q <= '0;
            limit_q <= '0;
        end else begin
            nonce_q <= nonce_d;
            limit_q <= limit_d;
        end
    end

    assign nonce = nonce_q;
    assign last  = (nonce_q == limit_q);

endmodule

// File: rtl/control_minado.sv
// Mining sweep controller: walks nonces from base to limit, hands each one
// to an external hash core over a req/ack handshake, and stops on the first
// truncated hash below target or when the limit nonce has been tried.
module control_minado
    import control_minado_pkg::*;
#(
    parameter int NONCE_W = NONCE_W_DEF,
    parameter int HASH_W  = HASH_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NONCE_W-1:0]    nonce_base,
    input  logic [NONCE_W-1:0]    nonce_limit,
    input  logic [HASH_W-1:0]     target,
    output logic                  hash_req,
    output logic [NONCE_W-1:0]    hash_nonce,
    input  logic                  hash_ack,
    input  logic                  hash_done,
    input  logic [HASH_W-1:0]     hash_value,
    output logic                  busy,
    output logic                  done,
    output logic                  found,
    output logic                  exhausted,
    output logic [NONCE_W-1:0]    nonce_found,
    output logic [ATTEMPTS_W-1:0] attempts
);

    state_e                state_q;
    state_e                state_d;
    logic [HASH_W-1:0]     target_q;
    logic [HASH_W-1:0]     target_d;
    logic [HASH_W-1:0]     hash_cap_q;
    logic [HASH_W-1:0]     hash_cap_d;
    logic [ATTEMPTS_W-1:0] attempts_q;
    logic [ATTEMPTS_W-1:0] attempts_d;
    logic                  found_q;
    logic                  found_d;
    logic                  exhausted_q;
    logic                  exhausted_d;
    logic [NONCE_W-1:0]    nonce_found_q;
    logic [NONCE_W-1:0]    nonce_found_d;
    logic                  hash_req_q;
    logic                  hash_req_d;
    logic                  busy_q;
    logic                  busy_d;
    logic                  done_q;
    logic                  done_d;

    logic                  gen_load;
    logic                  gen_inc;
    logic [NONCE_W-1:0]    gen_nonce;
    logic                  gen_last;

    generador_nonce #(
        .NONCE_W (NONCE_W)
    ) u_generador_nonce (
        .clk   (clk),
        .reset (reset),
        .load  (gen_load),
        .inc   (gen_inc),
        .base  (nonce_base),
        .limit (nonce_limit),
        .nonce (gen_nonce),
        .last  (gen_last)
    );

    // Next-state and result logic; outputs are derived from the next state so they come out registered.
    always_comb begin
        state_d       = state_q;
        target_d      = target_q;
        hash_cap_d    = hash_cap_q;
        attempts_d    = attempts_q;
        found_d       = found_q;
        exhausted_d   = exhausted_q;
        nonce_found_d = nonce_found_q;
        gen_load      = 1'b0;
        gen_inc       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    target_d      = target;
                    attempts_d    = '0;
                    found_d       = 1'b0;
                    exhausted_d   = 1'b0;
                    nonce_found_d = '0;
                    gen_load      = 1'b1;
                    if (nonce_base > nonce_limit) begin
                        exhausted_d = 1'b1;
                        state_d     = ST_FINISH;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end

            ST_ISSUE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (hash_ack) begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (abort) begin
                    // A result arriving in the same cycle as abort already ends the drain.
                    state_d = hash_done ? ST_IDLE : ST_DRAIN;
                end else if (hash_done) begin
                    hash_cap_d = hash_value;
                    attempts_d = sat_inc(attempts_q);
                    state_d    = ST_CHECK;
                end
            end

            ST_CHECK: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (hash_cap_q < target_q) begin
                    found_d       = 1'b1;
                    nonce_found_d = gen_nonce;
                    state_d       = ST_FINISH;
                end else if (gen_last) begin
                    exhausted_d = 1'b1;
                    state_d     = ST_FINISH;
                end else begin
                    gen_inc = 1'b1;
                    state_d = ST_ISSUE;
                end
            end

            ST_DRAIN: begin
                if (hash_done) begin
                    state_d = ST_IDLE;
                end
            end

            ST_FINISH: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        hash_req_d = (state_d == ST_ISSUE);
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_FINISH);
    end

    // All controller state and registered outputs, cleared by synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            target_q      <= '0;
            hash_cap_q    <= '0;
            attempts_q    <= '0;
            found_q       <= 1'b0;
            exhausted_q   <= 1'b0;
            nonce_found_q <= '0;
            hash_req_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            target_q      <= target_d;
            hash_cap_q    <= hash_cap_d;
            attempts_q    <= attempts_d;
            found_q       <= found_d;
            exhausted_q   <= exhausted_d;
            nonce_found_q <= nonce_found_d;
            hash_req_q    <= hash_req_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign hash_req    = hash_req_q;
    assign hash_nonce  = gen_nonce;
    assign busy        = busy_q;
    assign done        = done_q;
    assign found       = found_q;
    assign exhausted   = exhausted_q;
    assign nonce_found = nonce_found_q;
    assign attempts    = attempts_q;

endmodule

// File: tb/tb_control_minado.sv
// Directed testbench for control_minado: the bench plays the hash core by
// hand and checks each scenario against hand-computed expectations.
module tb_control_minado;

    localparam int NW = 32;
    localparam int HW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [NW-1:0] nonce_base;
    logic [NW-1:0] nonce_limit;
    logic [HW-1:0] target;
    logic          hash_req;
    logic [NW-1:0] hash_nonce;
    logic          hash_ack;
    logic          hash_done;
    logic [HW-1:0] hash_value;
    logic          busy;
    logic          done;
    logic          found;
    logic          exhausted;
    logic [NW-1:0] nonce_found;
    logic [31:0]   attempts;

    int total = 0;
    int bad   = 0;

    int   done_pulses = 0;
    int   req_rises   = 0;
    logic req_prev    = 1'b0;

    logic [NW-1:0] seen_q[$];
    bit            sweep_ok;

    control_minado #(
        .NONCE_W (NW),
        .HASH_W  (HW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .nonce_base  (nonce_base),
        .nonce_limit (nonce_limit),
        .target      (target),
        .hash_req    (hash_req),
        .hash_nonce  (hash_nonce),
        .hash_ack    (hash_ack),
        .hash_done   (hash_done),
        .hash_value  (hash_value),
        .busy        (busy),
        .done        (done),
        .found       (found),
        .exhausted   (exhausted),
        .nonce_found (nonce_found),
        .attempts    (attempts)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Count done-high cycles and hash_req rising edges, sampled on the falling edge.
    always @(negedge clk) begin
        if (done === 1'b1) done_pulses <= done_pulses + 1;
        if (hash_req === 1'b1 && req_prev !== 1'b1) req_rises <= req_rises + 1;
        req_prev <= hash_req;
    end

    // Safety net in case something hangs outside the bounded loops.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Acts as the hash core for one request: waits for hash_req, holds ack off for ack_delay cycles, then returns a result.
    task automatic serve_one(input logic [NW-1:0] hit_n, input bit use_hit, input int ack_delay,
                             output logic [NW-1:0] nonce_seen, output bit ok);
        int n;
        ok = 1'b1;
        n  = 0;
        nonce_seen = '0;
        while (hash_req !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        if (hash_req !== 1'b1) begin
            ok = 1'b0;
            return;
        end
        nonce_seen = hash_nonce;
        for (int i = 0; i < ack_delay; i++) begin
            step();
            if (hash_req !== 1'b1 || hash_nonce !== nonce_seen) ok = 1'b0;
        end
        hash_ack = 1'b1;
        step();
        hash_ack = 1'b0;
        if (hash_req !== 1'b0) ok = 1'b0;
        step();
        hash_done  = 1'b1;
        hash_value = (use_hit && nonce_seen == hit_n) ? 32'h0000_000F : 32'hFFFF_FFFF;
        step();
        hash_done  = 1'b0;
        hash_value = '0;
    endtask

    // Runs a whole sweep with target 0x10 until done shows up, recording each nonce issued.
    task automatic run_sweep(input logic [NW-1:0] base, input logic [NW-1:0] limit,
                             input logic [NW-1:0] hit_n, input bit use_hit, input int ack_delay);
        logic [NW-1:0] n;
        bit            ok;
        bit            finished;
        seen_q.delete();
        sweep_ok    = 1'b1;
        finished    = 1'b0;
        nonce_base  = base;
        nonce_limit = limit;
        target      = 32'h10;
        start       = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            serve_one(hit_n, use_hit, ack_delay, n, ok);
            if (!ok) begin
                sweep_ok = 1'b0;
                break;
            end
            seen_q.push_back(n);
            step();
            if (done === 1'b1) begin
                finished = 1'b1;
                break;
            end
        end
        if (!finished) sweep_ok = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%0b want=0", busy); end
        total++; if (hash_req !== 1'b0) begin bad++; $display("[TB] FAIL reset_req got=%0b want=0", hash_req); end
        total++; if ({done, found, exhausted} !== 3'b000) begin bad++; $display("[TB] FAIL reset_flags got=%b want=000", {done, found, exhausted}); end
        total++; if (attempts !== 32'd0) begin bad++; $display("[TB] FAIL reset_attempts got=%0d want=0", attempts); end
        total++; if (hash_nonce !== 32'd0 || nonce_found !== 32'd0) begin bad++; $display("[TB] FAIL reset_nonces got=%0h/%0h want=0/0", hash_nonce, nonce_found); end
        reset = 1'b1;
        step();
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL idle_after_reset got=%0b want=0", busy); end
    endtask

    task automatic test_found();
        int d0 = done_pulses;
        run_sweep(32'd5, 32'd9, 32'd7, 1'b1, 0);
        total++; if (sweep_ok !== 1'b1) begin bad++; $display("[TB] FAIL found_handshake got=%0b want=1", sweep_ok); end
        total++; if (found !== 1'b1 || exhausted !== 1'b0) begin bad++; $display("[TB] FAIL found_flags got=%0b%0b want=10", found, exhausted); end
        total++; if (nonce_found !== 32'd7) begin bad++; $display("[TB] FAIL found_nonce got=%0d want=7", nonce_found); end
        total++; if (attempts !== 32'd3) begin bad++; $display("[TB] FAIL found_attempts got=%0d want=3", attempts); end
        total++; if (done_pulses - d0 !== 1) begin bad++; $display("[TB] FAIL found_done_cycles got=%0d want=1", done_pulses - d0); end
        total++; if (seen_q.size() !== 3) begin bad++; $display("[TB] FAIL found_req_count got=%0d want=3", seen_q.size()); end
        for (int i = 0; i < seen_q.size(); i++) begin
            total++; if (seen_q[i] !== 32'd5 + 32'(i)) begin bad++; $display("[TB] FAIL found_seq[%0d] got=%0d want=%0d", i, seen_q[i], 5 + i); end
        end
        step();
        step();
        total++; if (found !== 1'b1 || attempts !== 32'd3 || busy !== 1'b0) begin bad++; $display("[TB] FAIL found_hold got=%0b/%0d/%0b want=1/3/0", found, attempts, busy); end
    endtask

    task automatic test_exhaust();
        run_sweep(32'd0, 32'd3, 32'd0, 1'b0, 0);
        total++; if (sweep_ok !== 1'b1) begin bad++; $display("[TB] FAIL exh_handshake got=%0b want=1", sweep_ok); end
        total++; if (exhausted !== 1'b1 || found !== 1'b0) begin bad++; $display("[TB] FAIL exh_flags got=%0b%0b want=10", exhausted, found); end
        total++; if (attempts !== 32'd4) begin bad++; $display("[TB] FAIL exh_attempts got=%0d want=4", attempts); end
        total++; if (nonce_found !== 32'd0) begin bad++; $display("[TB] FAIL exh_nonce_found got=%0h want=0", nonce_found); end
        total++; if (seen_q.size() !== 4) begin bad++; $display("[TB] FAIL exh_req_count got=%0d want=4", seen_q.size()); end
        for (int i = 0; i < seen_q.size(); i++) begin
            total++; if (seen_q[i] !== 32'(i)) begin bad++; $display("[TB] FAIL exh_seq[%0d] got=%0d want=%0d", i, seen_q[i], i); end
        end
    endtask

    task automatic test_top_limit();
        int r0 = req_rises;
        run_sweep(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 0);
        for (int i = 0; i < 5; i++) step();
        total++; if (exhausted !== 1'b1 || attempts !== 32'd1) begin bad++; $display("[TB] FAIL top_result got=%0b/%0d want=1/1", exhausted, attempts); end
        total++; if (req_rises - r0 !== 1) begin bad++; $display("[TB] FAIL top_req_count got=%0d want=1", req_rises - r0); end
        total++; if (hash_nonce !== 32'hFFFF_FFFF) begin bad++; $display("[TB] FAIL top_no_wrap got=%0h want=ffffffff", hash_nonce); end
    endtask

    task automatic test_ack_delay();
        int r0 = req_rises;
        run_sweep(32'd10, 32'd11, 32'd0, 1'b0, 5);
        total++; if (sweep_ok !== 1'b1) begin bad++; $display("[TB] FAIL delay_stable got=%0b want=1", sweep_ok); end
        total++; if (req_rises - r0 !== 2) begin bad++; $display("[TB] FAIL delay_req_count got=%0d want=2", req_rises - r0); end
        total++; if (attempts !== 32'd2 || exhausted !== 1'b1) begin bad++; $display("[TB] FAIL delay_result got=%0d/%0b want=2/1", attempts, exhausted); end
    endtask

    task automatic test_match_and_limit();
        run_sweep(32'd3, 32'd3, 32'd3, 1'b1, 0);
        total++; if (found !== 1'b1 || exhausted !== 1'b0) begin bad++; $display("[TB] FAIL prio_flags got=%0b%0b want=10", found, exhausted); end
        total++; if (nonce_found !== 32'd3 || attempts !== 32'd1) begin bad++; $display("[TB] FAIL prio_values got=%0d/%0d want=3/1", nonce_found, attempts); end
    endtask

    task automatic test_stray_done();
        hash_done  = 1'b1;
        hash_value = 32'd0;
        step();
        hash_done = 1'b0;
        step();
        total++; if (attempts !== 32'd1 || busy !== 1'b0 || nonce_found !== 32'd3) begin bad++; $display("[TB] FAIL stray_done got=%0d/%0b/%0d want=1/0/3", attempts, busy, nonce_found); end
    endtask

    task automatic test_base_gt_limit();
        nonce_base  = 32'd9;
        nonce_limit = 32'd5;
        start = 1'b1;
        step();
        start = 1'b0;
        total++; if ({busy, done, exhausted, found} !== 4'b1110) begin bad++; $display("[TB] FAIL bgl_finish got=%b want=1110", {busy, done, exhausted, found}); end
        total++; if (attempts !== 32'd0 || hash_req !== 1'b0) begin bad++; $display("[TB] FAIL bgl_no_req got=%0d/%0b want=0/0", attempts, hash_req); end
        step();
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("[TB] FAIL bgl_idle got=%0b%0b want=00", busy, done); end
    endtask

    task automatic test_start_abort_idle();
        nonce_base  = 32'd0;
        nonce_limit = 32'd5;
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        step();
        total++; if (busy !== 1'b0 || hash_req !== 1'b0 || exhausted !== 1'b1) begin bad++; $display("[TB] FAIL start_abort got=%0b/%0b/%0b want=0/0/1", busy, hash_req, exhausted); end
    endtask

    task automatic test_abort_issue();
        int d0 = done_pulses;
        nonce_base  = 32'd0;
        nonce_limit = 32'd5;
        start = 1'b1;
        step();
        start = 1'b0;
        total++; if (hash_req !== 1'b1 || busy !== 1'b1) begin bad++; $display("[TB] FAIL abi_issue got=%0b%0b want=11", hash_req, busy); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
        total++; if (busy !== 1'b0 || hash_req !== 1'b0 || done_pulses - d0 !== 0) begin bad++; $display("[TB] FAIL abi_idle got=%0b/%0b/%0d want=0/0/0", busy, hash_req, done_pulses - d0); end
    endtask

    task automatic test_abort_wait();
        int            d0 = done_pulses;
        logic [NW-1:0] n;
        bit            ok;
        nonce_base  = 32'd0;
        nonce_limit = 32'd9;
        target      = 32'h10;
        start = 1'b1;
        step();
        start = 1'b0;
        serve_one(32'd0, 1'b0, 0, n, ok);
        step();
        total++; if (hash_req !== 1'b1 || hash_nonce !== 32'd1 || attempts !== 32'd1) begin bad++; $display("[TB] FAIL abw_second got=%0b/%0d/%0d want=1/1/1", hash_req, hash_nonce, attempts); end
        hash_ack = 1'b1;
        step();
        hash_ack = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        total++; if (busy !== 1'b1 || hash_req !== 1'b0) begin bad++; $display("[TB] FAIL abw_drain got=%0b%0b want=10", busy, hash_req); end
        hash_done  = 1'b1;
        hash_value = 32'd0;
        step();
        hash_done = 1'b0;
        step();
        total++; if (busy !== 1'b0 || found !== 1'b0) begin bad++; $display("[TB] FAIL abw_idle got=%0b%0b want=00", busy, found); end
        total++; if (attempts !== 32'd1 || done_pulses - d0 !== 0) begin bad++; $display("[TB] FAIL abw_attempts got=%0d/%0d want=1/0", attempts, done_pulses - d0); end
    endtask

    task automatic test_reset_mid_wait();
        nonce_base  = 32'd4;
        nonce_limit = 32'd8;
        start = 1'b1;
        step();
        start = 1'b0;
        hash_ack = 1'b1;
        step();
        hash_ack = 1'b0;
        reset = 1'b0;
        step();
        reset = 1'b1;
        total++; if ({busy, done, found, exhausted, hash_req} !== 5'b00000) begin bad++; $display("[TB] FAIL rmw_flags got=%b want=00000", {busy, done, found, exhausted, hash_req}); end
        total++; if (attempts !== 32'd0 || hash_nonce !== 32'd0 || nonce_found !== 32'd0) begin bad++; $display("[TB] FAIL rmw_values got=%0d/%0d/%0d want=0/0/0", attempts, hash_nonce, nonce_found); end
        step();
        run_sweep(32'd2, 32'd2, 32'd2, 1'b1, 0);
        total++; if (found !== 1'b1 || nonce_found !== 32'd2 || attempts !== 32'd1) begin bad++; $display("[TB] FAIL rmw_rerun got=%0b/%0d/%0d want=1/2/1", found, nonce_found, attempts); end
    endtask

    // Test sequence.
    initial begin
        reset       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        hash_ack    = 1'b0;
        hash_done   = 1'b0;
        hash_value  = '0;
        nonce_base  = '0;
        nonce_limit = '0;
        target      = '0;

        test_reset();
        test_found();
        test_exhaust();
        test_top_limit();
        test_ack_delay();
        test_match_and_limit();
        test_stray_done();
        test_base_gt_limit();
        test_start_abort_idle();
        test_abort_issue();
        test_abort_wait();
        test_reset_mid_wait();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
